// File: rtl/ex_stage.sv
//==============================================================================
// Module   : ex_stage
// Brief    : MIPS execute stage with ALU, HI/LO and a 32-step iterative divider.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module ex_stage (
    input  logic         clk,
    input  logic         rst,
    input  logic [5:0]   stall,
    input  logic [158:0] id_to_ex_bus,
    output logic [75:0]  ex_to_mem_bus,
    output logic [75:0]  ex_to_id_bus,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_wen,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata,
    output logic         stallreq_for_ex
);

    localparam int ID_TO_EX_WD  = 159;
    localparam int EX_TO_MEM_WD = 76;

    localparam logic [5:0] C_FUNCT_MFHI = 6'h10;
    localparam logic [5:0] C_FUNCT_MTHI = 6'h11;
    localparam logic [5:0] C_FUNCT_MFLO = 6'h12;
    localparam logic [5:0] C_FUNCT_MTLO = 6'h13;
    localparam logic [5:0] C_FUNCT_DIV  = 6'h1A;
    localparam logic [5:0] C_FUNCT_DIVU = 6'h1B;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    logic [ID_TO_EX_WD-1:0] id_q, id_d;
    logic                   valid_q, valid_d;

    always_comb begin
        id_d    = id_q;
        valid_d = valid_q;
        if (stall[2] && !stall[3]) begin
            id_d    = '0;
            valid_d = 1'b0;
        end else if (!stall[2]) begin
            id_d    = id_to_ex_bus;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            id_q    <= id_d;
            valid_q <= valid_d;
        end
    end

    logic [31:0] w_pc, w_inst, w_rs, w_rt;
    logic [11:0] w_alu_op;
    logic [2:0]  w_sel1;
    logic [3:0]  w_sel2;
    logic        w_ram_en, w_rf_we, w_sel_rf_res;
    logic [3:0]  w_ram_wen;
    logic [4:0]  w_rf_waddr;

    assign w_pc         = id_q[158:127];
    assign w_inst       = id_q[126:95];
    assign w_alu_op     = id_q[94:83];
    assign w_sel1       = id_q[82:80];
    assign w_sel2       = id_q[79:76];
    assign w_ram_en     = id_q[75];
    assign w_ram_wen    = id_q[74:71];
    assign w_rf_we      = id_q[70];
    assign w_rf_waddr   = id_q[69:65];
    assign w_sel_rf_res = id_q[64];
    assign w_rs         = id_q[63:32];
    assign w_rt         = id_q[31:0];

    logic [31:0] w_src1, w_src2, w_alu_res, w_sum, w_diff, w_ex_result;
    logic        w_slt, w_sltu;

    assign w_src1 = ({32{w_sel1[0]}} & w_rs)
                  | ({32{w_sel1[1]}} & w_pc)
                  | ({32{w_sel1[2]}} & {27'b0, w_inst[10:6]});
    assign w_src2 = ({32{w_sel2[0]}} & w_rt)
                  | ({32{w_sel2[1]}} & {{16{w_inst[15]}}, w_inst[15:0]})
                  | ({32{w_sel2[2]}} & 32'd8)
                  | ({32{w_sel2[3]}} & {16'b0, w_inst[15:0]});

    assign w_sum  = w_src1 + w_src2;
    assign w_diff = w_src1 - w_src2;
    assign w_slt  = $signed(w_src1) < $signed(w_src2);
    assign w_sltu = w_src1 < w_src2;

    assign w_alu_res = ({32{w_alu_op[11]}} & w_sum)
                     | ({32{w_alu_op[10]}} & w_diff)
                     | ({32{w_alu_op[9]}}  & {31'b0, w_slt})
                     | ({32{w_alu_op[8]}}  & {31'b0, w_sltu})
                     | ({32{w_alu_op[7]}}  & (w_src1 & w_src2))
                     | ({32{w_alu_op[6]}}  & ~(w_src1 | w_src2))
                     | ({32{w_alu_op[5]}}  & (w_src1 | w_src2))
                     | ({32{w_alu_op[4]}}  & (w_src1 ^ w_src2))
                     | ({32{w_alu_op[3]}}  & (w_src2 << w_src1[4:0]))
                     | ({32{w_alu_op[2]}}  & (w_src2 >> w_src1[4:0]))
                     | ({32{w_alu_op[1]}}  & 32'($signed(w_src2) >>> w_src1[4:0]))
                     | ({32{w_alu_op[0]}}  & {w_src2[15:0], 16'b0});

    logic w_rtype, w_is_div, w_is_divs, w_mfhi, w_mflo, w_mthi, w_mtlo;

    assign w_rtype   = valid_q && (w_inst[31:26] == 6'd0);
    assign w_is_divs = w_rtype && (w_inst[5:0] == C_FUNCT_DIV);
    assign w_is_div  = w_is_divs || (w_rtype && (w_inst[5:0] == C_FUNCT_DIVU));
    assign w_mfhi    = w_rtype && (w_inst[5:0] == C_FUNCT_MFHI);
    assign w_mflo    = w_rtype && (w_inst[5:0] == C_FUNCT_MFLO);
    assign w_mthi    = w_rtype && (w_inst[5:0] == C_FUNCT_MTHI);
    assign w_mtlo    = w_rtype && (w_inst[5:0] == C_FUNCT_MTLO);

    div_state_t  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d, dq_q, dq_d, dvs_q, dvs_d, hi_q, hi_d, lo_q, lo_d;
    logic        sgn_q, sgn_d, ndvd_q, ndvd_d, ndvs_q, ndvs_d;

    logic [31:0] w_rs_mag, w_rt_mag, w_q_fix, w_r_fix;
    logic [32:0] w_part, w_trial;
    logic        w_ge;

    assign w_rs_mag = (w_is_divs && w_rs[31]) ? (32'd0 - w_rs) : w_rs;
    assign w_rt_mag = (w_is_divs && w_rt[31]) ? (32'd0 - w_rt) : w_rt;

    // Restoring step: shift the next dividend bit into the partial remainder.
    assign w_part  = {rem_q, dq_q[31]};
    assign w_trial = w_part - {1'b0, dvs_q};
    assign w_ge    = !w_trial[32];

    assign w_q_fix = (sgn_q && (ndvd_q ^ ndvs_q)) ? (32'd0 - dq_q) : dq_q;
    assign w_r_fix = (sgn_q && ndvd_q) ? (32'd0 - rem_q) : rem_q;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        rem_d           = rem_q;
        dq_d            = dq_q;
        dvs_d           = dvs_q;
        sgn_d           = sgn_q;
        ndvd_d          = ndvd_q;
        ndvs_d          = ndvs_q;
        hi_d            = hi_q;
        lo_d            = lo_q;
        stallreq_for_ex = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_is_div) begin
                    stallreq_for_ex = 1'b1;
                    sgn_d  = w_is_divs;
                    ndvd_d = w_is_divs && w_rs[31];
                    ndvs_d = w_is_divs && w_rt[31];
                    dvs_d  = w_rt_mag;
                    cnt_d  = 6'd0;
                    if (w_rt == 32'd0) begin
                        dq_d    = 32'hFFFF_FFFF;
                        rem_d   = w_rs_mag;
                        state_d = S_DONE;
                    end else begin
                        dq_d    = w_rs_mag;
                        rem_d   = 32'd0;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                stallreq_for_ex = 1'b1;
                rem_d = w_ge ? w_trial[31:0] : w_part[31:0];
                dq_d  = {dq_q[30:0], w_ge};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!stall[2]) begin
                    hi_d    = w_r_fix;
                    lo_d    = w_q_fix;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (!stall[2] && w_mthi) hi_d = w_rs;
        if (!stall[2] && w_mtlo) lo_d = w_rs;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            rem_q   <= 32'd0;
            dq_q    <= 32'd0;
            dvs_q   <= 32'd0;
            sgn_q   <= 1'b0;
            ndvd_q  <= 1'b0;
            ndvs_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dq_q    <= dq_d;
            dvs_q   <= dvs_d;
            sgn_q   <= sgn_d;
            ndvd_q  <= ndvd_d;
            ndvs_q  <= ndvs_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign w_ex_result = w_mfhi ? hi_q : (w_mflo ? lo_q : w_alu_res);

    logic [EX_TO_MEM_WD-1:0] w_out_bus;

    assign w_out_bus = {w_pc, w_ram_en, w_ram_wen, w_sel_rf_res,
                        w_rf_we && !w_is_div, w_rf_waddr, w_ex_result};

    assign ex_to_mem_bus   = w_out_bus;
    assign ex_to_id_bus    = w_out_bus;
    assign data_sram_en    = valid_q && w_ram_en;
    assign data_sram_wen   = valid_q ? w_ram_wen : 4'd0;
    assign data_sram_addr  = valid_q ? w_ex_result : 32'd0;
    assign data_sram_wdata = valid_q ? w_rt : 32'd0;

    logic w_unused;
    assign w_unused = ^{stall[5:4], stall[1:0], w_inst[25:16]};

endmodule

`default_nettype wire

// File: tb/tb_ex_stage.sv
//==============================================================================
// Module   : tb_ex_stage
// Brief    : Directed vector bench for ex_stage (ALU table plus divide sequences).
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_ex_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall;
    logic [158:0] id_bus;
    logic [75:0]  mem_bus, id_fwd_bus;
    logic         sram_en;
    logic [3:0]   sram_wen;
    logic [31:0]  sram_addr, sram_wdata;
    logic         stallreq;

    ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .id_to_ex_bus    (id_bus),
        .ex_to_mem_bus   (mem_bus),
        .ex_to_id_bus    (id_fwd_bus),
        .data_sram_en    (sram_en),
        .data_sram_wen   (sram_wen),
        .data_sram_addr  (sram_addr),
        .data_sram_wdata (sram_wdata),
        .stallreq_for_ex (stallreq)
    );

    always #5 clk = ~clk;

    localparam logic [11:0] OP_ADD = 12'h800, OP_SUB = 12'h400, OP_SLT = 12'h200,
                            OP_SLTU = 12'h100, OP_AND = 12'h080, OP_NOR = 12'h040,
                            OP_OR = 12'h020, OP_XOR = 12'h010, OP_SLL = 12'h008,
                            OP_SRL = 12'h004, OP_SRA = 12'h002, OP_LUI = 12'h001;

    typedef struct {
        logic [158:0] bus;
        logic [31:0]  res;
    } vec_t;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [75:0] act, input logic [75:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] inst,
                                        input logic [11:0] op, input logic [2:0] s1,
                                        input logic [3:0] s2, input logic en,
                                        input logic [3:0] wen, input logic we,
                                        input logic [4:0] wa, input logic sel,
                                        input logic [31:0] rs, input logic [31:0] rt);
        return {pc, inst, op, s1, s2, en, wen, we, wa, sel, rs, rt};
    endfunction

    function automatic logic [75:0] ebus(input logic [158:0] b, input logic [31:0] res,
                                         input logic we);
        return {b[158:127], b[75], b[74:71], b[64], we, b[69:65], res};
    endfunction

    task automatic load(input logic [158:0] b, input logic [5:0] st);
        @(negedge clk);
        id_bus = b;
        stall  = st;
        @(posedge clk);
        #1;
    endtask

    task automatic run_div(input logic [158:0] b, output int scnt);
        load(b, 6'd0);
        scnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!stallreq) break;
            scnt++;
            stall = 6'b001111;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic read_hilo(input string name, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo);
        logic [158:0] mflo, mfhi;
        mflo = mk(32'h300, 32'h0000_4012, 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b1, 5'd8, 1'b0, 32'd0, 32'd0);
        mfhi = mk(32'h304, 32'h0000_4810, 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b1, 5'd9, 1'b0, 32'd0, 32'd0);
        load(mflo, 6'd0);
        chk({name, "_mflo"}, mem_bus, ebus(mflo, exp_lo, 1'b1));
        load(mfhi, 6'd0);
        chk({name, "_mfhi"}, mem_bus, ebus(mfhi, exp_hi, 1'b1));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    vec_t         tbl [15];
    logic [158:0] divb, sw, mthi;
    int           scnt;

    initial begin
        tbl[0]  = '{mk(32'h0,   32'h0043_0821, OP_ADD,  3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd1,  1'b0, 32'h7FFF_FFFF, 32'h1), 32'h8000_0000};
        tbl[1]  = '{mk(32'h4,   32'h0000_0100, OP_SLL,  3'b100, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd2,  1'b0, 32'h0, 32'hF), 32'h0000_00F0};
        tbl[2]  = '{mk(32'h8,   32'h3C01_1234, OP_LUI,  3'b000, 4'b1000, 1'b0, 4'h0, 1'b1, 5'd1,  1'b0, 32'h5, 32'h6), 32'h1234_0000};
        tbl[3]  = '{mk(32'h100, 32'h0C00_0000, OP_ADD,  3'b010, 4'b0100, 1'b0, 4'h0, 1'b1, 5'd31, 1'b0, 32'h0, 32'h0), 32'h0000_0108};
        tbl[4]  = '{mk(32'h10,  32'h0000_0023, OP_SUB,  3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd3,  1'b0, 32'h5, 32'h7), 32'hFFFF_FFFE};
        tbl[5]  = '{mk(32'h14,  32'h0000_002A, OP_SLT,  3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd4,  1'b0, 32'hFFFF_FFFF, 32'h1), 32'h1};
        tbl[6]  = '{mk(32'h18,  32'h0000_002B, OP_SLTU, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd5,  1'b0, 32'hFFFF_FFFF, 32'h1), 32'h0};
        tbl[7]  = '{mk(32'h1C,  32'h0000_0027, OP_NOR,  3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd6,  1'b0, 32'h0F0F_0F0F, 32'h00FF_00FF), 32'hF000_F000};
        tbl[8]  = '{mk(32'h20,  32'h0000_0103, OP_SRA,  3'b100, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd7,  1'b0, 32'h0, 32'h8000_0000), 32'hF800_0000};
        tbl[9]  = '{mk(32'h24,  32'h0000_0102, OP_SRL,  3'b100, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd8,  1'b0, 32'h0, 32'h8000_0000), 32'h0800_0000};
        tbl[10] = '{mk(32'h200, 32'hAC43_FFFC, OP_ADD,  3'b001, 4'b0010, 1'b1, 4'hF, 1'b0, 5'd0,  1'b0, 32'h1000, 32'hDEAD_BEEF), 32'h0000_0FFC};
        tbl[11] = '{mk(32'h204, 32'h8C43_0010, OP_ADD,  3'b001, 4'b0010, 1'b1, 4'h0, 1'b1, 5'd3,  1'b1, 32'h2000, 32'h1234), 32'h0000_2010};
        tbl[12] = '{mk(32'h28,  32'h0000_0026, OP_XOR,  3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd9,  1'b0, 32'hA5A5_A5A5, 32'hFFFF_0000), 32'h5A5A_A5A5};
        tbl[13] = '{mk(32'h2C,  32'h3442_8000, OP_OR,   3'b001, 4'b1000, 1'b0, 4'h0, 1'b1, 5'd2,  1'b0, 32'h1, 32'h0), 32'h0000_8001};
        tbl[14] = '{mk(32'h30,  32'h0000_0024, OP_AND,  3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd10, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00), 32'hF000_F000};

        // Reset state, with a live instruction on the input that must not load.
        rst    = 1'b1;
        stall  = 6'd0;
        id_bus = tbl[0].bus;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_mem_bus", mem_bus, 76'd0);
        chk("reset_id_bus", id_fwd_bus, 76'd0);
        chk("reset_sram", {sram_en, sram_wen, sram_addr, sram_wdata}, 76'd0);
        chk("reset_stallreq", stallreq, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            load(tbl[i].bus, 6'd0);
            chk($sformatf("vec%0d_mem_bus", i), mem_bus, ebus(tbl[i].bus, tbl[i].res, tbl[i].bus[70]));
            chk($sformatf("vec%0d_id_bus", i), id_fwd_bus, ebus(tbl[i].bus, tbl[i].res, tbl[i].bus[70]));
            chk($sformatf("vec%0d_sram", i), {sram_en, sram_wen, sram_addr, sram_wdata},
                {tbl[i].bus[75], tbl[i].bus[74:71], tbl[i].res, tbl[i].bus[31:0]});
        end

        // DIVU 100 / 7
        divb = mk(32'h400, 32'h0085_001B, 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b1, 5'd0, 1'b0, 32'd100, 32'd7);
        run_div(divb, scnt);
        chk("divu_stall_cycles", 76'(scnt), 76'd33);
        chk("divu_rf_we_forced_low", mem_bus[37], 1'b0);
        read_hilo("divu", 32'd2, 32'd14);

        // DIV -7 / 2
        divb = mk(32'h410, 32'h0085_001A, 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b1, 5'd0, 1'b0, 32'hFFFF_FFF9, 32'd2);
        run_div(divb, scnt);
        chk("div_neg_stall_cycles", 76'(scnt), 76'd33);
        read_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // DIV 7 / 0
        divb = mk(32'h420, 32'h0085_001A, 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b1, 5'd0, 1'b0, 32'd7, 32'd0);
        run_div(divb, scnt);
        chk("div_zero_stall_cycles", 76'(scnt), 76'd1);
        read_hilo("div_zero", 32'd7, 32'hFFFF_FFFF);

        // MTHI then MFHI/MFLO
        mthi = mk(32'h430, 32'h0080_0011, 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0, 32'hABCD_1234, 32'd0);
        load(mthi, 6'd0);
        read_hilo("mthi", 32'hABCD_1234, 32'hFFFF_FFFF);

        // Bubble insertion: EX stopped, MEM running
        sw = tbl[10].bus;
        load(sw, 6'd0);
        chk("pre_bubble_sram_en", sram_en, 1'b1);
        load(tbl[0].bus, 6'b000100);
        chk("bubble_mem_bus", mem_bus, 76'd0);
        chk("bubble_sram", {sram_en, sram_wen, sram_addr, sram_wdata}, 76'd0);

        // Hold: EX and MEM both stopped
        load(sw, 6'd0);
        load(tbl[0].bus, 6'b001100);
        chk("hold_mem_bus", mem_bus, ebus(sw, 32'h0000_0FFC, 1'b0));
        chk("hold_sram_en", sram_en, 1'b1);

        // Reset in the middle of a divide
        divb = mk(32'h440, 32'h0085_001B, 12'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b1, 5'd0, 1'b0, 32'd100, 32'd7);
        load(divb, 6'd0);
        for (int i = 0; i < 11; i++) begin
            stall = 6'b001111;
            @(posedge clk);
            #1;
        end
        chk("mid_div_stallreq", stallreq, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_rst_stallreq", stallreq, 1'b0);
        chk("async_rst_mem_bus", mem_bus, 76'd0);
        #1;
        rst = 1'b0;
        read_hilo("after_rst", 32'd0, 32'd0);
        chk("after_rst_stallreq", stallreq, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
